// File: rtl/i2c_txbuf_sched.sv
// i2c_txbuf_sched: ping-pong transmit buffers feeding the I2C serializer with ack timeout, retry and drop
module i2c_txbuf_sched #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 4,
    parameter int ACK_TIMEOUT = 64,
    parameter int MAX_RETRY   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] tx_in,
    output logic              wr_ready,
    input  logic              start_tx,
    input  logic              ser_busy,
    input  logic              ack_recvd,
    output logic              ser_load,
    output logic [ADDR_W-1:0] ser_addr,
    output logic [DATA_W-1:0] ser_data,
    output logic [1:0]        buf_valid,
    output logic              fill_sel,
    output logic              tx_sel,
    output logic              tx_done,
    output logic              tx_drop
);
    localparam int CW = $clog2(ACK_TIMEOUT);
    localparam int RW = $clog2(MAX_RETRY + 2);
    typedef enum logic [1:0] {IDLE, LOAD, WAIT_ACK, RELEASE} state_t;
    state_t state, state_nx;
    logic [ADDR_W+DATA_W-1:0] buf_q [2];
    logic [CW-1:0] tcnt;
    logic [RW-1:0] retry;
    logic drop, wr_ok, tmo, can_retry;
    logic [1:0] set_m, clr_m;
    assign wr_ready  = !buf_valid[fill_sel];
    assign wr_ok     = write && wr_ready;
    assign tmo       = tcnt == CW'(ACK_TIMEOUT - 1);
    assign can_retry = retry < RW'(MAX_RETRY);
    assign set_m     = wr_ok ? 2'(1) << fill_sel : 2'b00;
    assign clr_m     = state == RELEASE ? 2'(1) << tx_sel : 2'b00;
    assign ser_load  = state == LOAD;
    assign tx_done   = state == RELEASE && !drop;
    assign tx_drop   = state == RELEASE && drop;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     state_nx = start_tx && buf_valid[tx_sel] && !ser_busy ? LOAD : IDLE;
            LOAD:     state_nx = WAIT_ACK;
            WAIT_ACK: state_nx = ack_recvd ? RELEASE : !tmo ? WAIT_ACK : can_retry ? LOAD : RELEASE;
            default:  state_nx = IDLE;
        endcase
    end
    // Buffer storage carries no reset; buf_valid alone says what is live
    always_ff @(posedge clk)
        if (wr_ok) buf_q[fill_sel] <= {addr, tx_in};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            tcnt      <= '0;
            retry     <= '0;
            drop      <= 1'b0;
            buf_valid <= 2'b00;
            fill_sel  <= 1'b0;
            tx_sel    <= 1'b0;
            ser_addr  <= '0;
            ser_data  <= '0;
        end else begin
            state     <= state_nx;
            buf_valid <= (buf_valid | set_m) & ~clr_m;
            tcnt      <= state == WAIT_ACK ? tcnt + CW'(1) : '0;
            if (wr_ok) fill_sel <= !fill_sel;
            if (state_nx == LOAD) {ser_addr, ser_data} <= buf_q[tx_sel];
            if (state == WAIT_ACK && !ack_recvd && tmo) begin
                if (can_retry) retry <= retry + RW'(1);
                else drop <= 1'b1;
            end
            if (state == RELEASE) begin
                tx_sel <= !tx_sel;
                retry  <= '0;
                drop   <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_i2c_txbuf_sched.sv
// tb_i2c_txbuf_sched: directed checks of buffering, ordering, retry/drop timing and reset behaviour
module tb_i2c_txbuf_sched;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        write = 1'b0;
    logic [3:0]  addr = '0;
    logic [31:0] tx_in = '0;
    logic        start_tx = 1'b0;
    logic        ser_busy = 1'b0;
    logic        ack_recvd = 1'b0;
    logic        wr_ready, ser_load, fill_sel, tx_sel, tx_done, tx_drop;
    logic [3:0]  ser_addr;
    logic [31:0] ser_data;
    logic [1:0]  buf_valid;
    int n_chk = 0, n_pass = 0;
    int cyc = 0, n_load = 0, n_done = 0, n_drop = 0;
    int lc [16];
    int b_load, b_done, b_drop;

    i2c_txbuf_sched dut (
        .clk(clk), .rst_n(rst_n), .write(write), .addr(addr), .tx_in(tx_in),
        .wr_ready(wr_ready), .start_tx(start_tx), .ser_busy(ser_busy),
        .ack_recvd(ack_recvd), .ser_load(ser_load), .ser_addr(ser_addr),
        .ser_data(ser_data), .buf_valid(buf_valid), .fill_sel(fill_sel),
        .tx_sel(tx_sel), .tx_done(tx_done), .tx_drop(tx_drop)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc++;
        if (ser_load) begin
            n_load++;
            lc[n_load % 16] = cyc;
        end
        if (tx_done) n_done++;
        if (tx_drop) n_drop++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        {write, start_tx, ser_busy, ack_recvd} = '0;
        tick;
        tick;
        rst_n = 1'b1;
        tick;
        b_load = n_load;
        b_done = n_done;
        b_drop = n_drop;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        write = 1'b1;
        addr  = a;
        tx_in = d;
        tick;
        write = 1'b0;
    endtask

    task automatic wait_load(input string tag);
        int k = 0;
        while (!ser_load && k < 300) begin
            tick;
            k++;
        end
        chk(tag, ser_load, 1);
    endtask

    task automatic ack_after_load;
        tick;
        tick;
        ack_recvd = 1'b1;
        tick;
        ack_recvd = 1'b0;
    endtask

    initial begin
        tick;
        chk("rst_valid", buf_valid, 0);
        chk("rst_sels", {fill_sel, tx_sel}, 0);
        chk("rst_pulses", {ser_load, tx_done, tx_drop}, 0);
        chk("rst_ser", {ser_addr, ser_data}, 0);
        chk("rst_wr_ready", wr_ready, 1);

        do_reset;
        wr(4'd0, 32'd2);
        chk("t1_valid", buf_valid, 2'b01);
        start_tx = 1'b1;
        tick;
        chk("t1_load", ser_load, 1);
        chk("t1_ser", {ser_addr, ser_data}, {4'd0, 32'd2});
        ack_after_load;
        chk("t1_done", {tx_done, tx_drop}, 2'b10);
        tick;
        tick;
        chk("t1_valid_end", buf_valid, 0);
        chk("t1_tx_sel", tx_sel, 1);
        chk("t1_counts", {8'(n_load - b_load), 8'(n_done - b_done)}, {8'd1, 8'd1});
        start_tx = 1'b0;

        do_reset;
        wr(4'd0, 32'd2);
        wr(4'd1, 32'd8);
        chk("t2_full", {buf_valid, wr_ready}, {2'b11, 1'b0});
        wr(4'd2, 32'd67);
        chk("t2_ignored", {buf_valid, fill_sel}, {2'b11, 1'b0});
        start_tx = 1'b1;
        wait_load("t2_load0");
        chk("t2_ser0", {ser_addr, ser_data}, {4'd0, 32'd2});
        ack_after_load;
        wait_load("t2_load1");
        chk("t2_ser1", {ser_addr, ser_data}, {4'd1, 32'd8});
        ack_after_load;
        repeat (10) tick;
        chk("t2_end", {buf_valid, tx_sel}, {2'b00, 1'b0});
        chk("t2_counts", {8'(n_load - b_load), 8'(n_done - b_done)}, {8'd2, 8'd2});
        start_tx = 1'b0;

        do_reset;
        wr(4'd5, 32'hA5);
        start_tx = 1'b1;
        repeat (210) tick;
        chk("t3_loads", n_load - b_load, 3);
        chk("t3_gap1", lc[(b_load + 2) % 16] - lc[(b_load + 1) % 16], 65);
        chk("t3_gap2", lc[(b_load + 3) % 16] - lc[(b_load + 2) % 16], 65);
        chk("t3_drop_done", {8'(n_drop - b_drop), 8'(n_done - b_done)}, {8'd1, 8'd0});
        chk("t3_end", {buf_valid, tx_sel}, {2'b00, 1'b1});
        start_tx = 1'b0;

        do_reset;
        wr(4'd7, 32'h55);
        start_tx = 1'b1;
        wait_load("t4_load1");
        tick;
        wait_load("t4_load2");
        tick;
        wait_load("t4_load3");
        repeat (64) tick;
        ack_recvd = 1'b1;
        tick;
        ack_recvd = 1'b0;
        chk("t4_release", {tx_done, tx_drop}, 2'b10);
        repeat (5) tick;
        chk("t4_counts", {8'(n_load - b_load), 8'(n_done - b_done), 8'(n_drop - b_drop)}, {8'd3, 8'd1, 8'd0});
        start_tx = 1'b0;

        do_reset;
        ser_busy = 1'b1;
        start_tx = 1'b1;
        wr(4'd3, 32'd9);
        repeat (5) tick;
        chk("t5_busy_hold", {ser_load, 8'(n_load - b_load)}, 0);
        ser_busy = 1'b0;
        tick;
        chk("t5_load", ser_load, 1);
        ack_after_load;
        chk("t5_done", tx_done, 1);
        start_tx = 1'b0;

        do_reset;
        wr(4'd1, 32'd1);
        wr(4'd2, 32'd2);
        start_tx = 1'b1;
        wait_load("t6_load");
        repeat (3) tick;
        rst_n = 1'b0;
        #1;
        chk("t6_async", {buf_valid, fill_sel, tx_sel, ser_load, tx_done, tx_drop}, 0);
        chk("t6_ser", {ser_addr, ser_data}, 0);
        tick;
        b_load = n_load;
        rst_n = 1'b1;
        repeat (5) tick;
        chk("t6_after", {wr_ready, fill_sel, buf_valid}, {1'b1, 1'b0, 2'b00});
        chk("t6_no_load", n_load - b_load, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/i2c_txbuf_sched.md
# i2c_txbuf_sched

Ping-pong transmit-buffer scheduler for the I2C master datapath. It accepts addressed 32-bit words from the host write port into two alternating buffers. It then hands one buffer at a time to the serializer, gated by `start_tx`, and waits for the slave acknowledge. A missing acknowledge leads to bounded retries and then a drop. The host can fill one buffer while the other is on the wire.

## Interface

Parameters:
- `DATA_W`, 32, word width.
- `ADDR_W`, 4, target address width.
- `ACK_TIMEOUT`, 64, cycles waited for `ack_recvd` per attempt (≥2).
- `MAX_RETRY`, 2, extra attempts after the first timeout.

Ports. One clock; reset is asynchronous and active-low.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `write` in 1: host write strobe.
- `addr` in ADDR_W: host target address.
- `tx_in` in DATA_W: host data.
- `wr_ready` out 1: buffer at `fill_sel` is free.
- `start_tx` in 1: level; enables draining.
- `ser_busy` in 1: serializer is occupied.
- `ack_recvd` in 1: slave acknowledge from the serializer.
- `ser_load` out 1: one-cycle load strobe.
- `ser_addr` out ADDR_W: address for the serializer.
- `ser_data` out DATA_W: data for the serializer.
- `buf_valid` out 2: per-buffer occupancy.
- `fill_sel` out 1: next buffer written.
- `tx_sel` out 1: next buffer drained.
- `tx_done` out 1: pulse on acknowledged word.
- `tx_drop` out 1: pulse on word dropped after retries.

## Operation
- Reset values:
  - `buf_valid`=0, `fill_sel`=0, `tx_sel`=0.
  - `ser_load`/`tx_done`/`tx_drop`=0.
  - `ser_addr`/`ser_data`=0.
  - FSM=IDLE; retry and timeout counters=0.
- Write side: `wr_ready` = !`buf_valid[fill_sel]`. A write is accepted when `write && wr_ready`. An accepted write:
  - stores {addr, tx_in} into buffer[`fill_sel`];
  - sets its valid bit;
  - toggles `fill_sel`.
- `write` while not ready is ignored: no state change and no overwrite.
- FSM states: IDLE, LOAD, WAIT_ACK, RELEASE.
- IDLE→LOAD: when `start_tx && buf_valid[tx_sel] && !ser_busy`.
- LOAD:
  - `ser_load`=1 for exactly this cycle;
  - `ser_addr`/`ser_data` = buffer[`tx_sel`], and they hold until the next LOAD;
  - timeout counter cleared;
  - next state WAIT_ACK.
- WAIT_ACK: the counter increments each cycle.
  - `ack_recvd` sampled high → RELEASE.
  - Else, counter reaching ACK_TIMEOUT-1 with retry < MAX_RETRY → retry+1, then LOAD.
  - Else, at that limit with retries exhausted → RELEASE with the drop flag set.
- RELEASE:
  - `tx_done`=1, or `tx_drop`=1 if dropped;
  - clears `buf_valid[tx_sel]`, toggles `tx_sel`, clears retry;
  - next state IDLE.
- `start_tx` low mid-transfer: the current word completes, including retries; no new LOAD starts.
- `ack_recvd` outside WAIT_ACK is ignored.
- Ack and timeout limit in the same cycle: ack wins and the outcome is `tx_done`.
- Same-cycle write and RELEASE on different buffers are both honoured. The valid bit a write sets and the one RELEASE clears are never the same: writes need a free buffer, and `tx_sel` always points at a full one.
- Order is strict FIFO: buffers alternate 0,1,0,1 on both sides.

## Timing
- Write accepted at edge E0 → `buf_valid` visible after E0.
- With IDLE, `start_tx`=1 and `!ser_busy`: LOAD from E1, so `ser_load` is high during E1–E2, and WAIT_ACK starts at E2.
- Ack sampled at edge Ek → RELEASE during Ek–Ek+1 → IDLE, buffer freed, `wr_ready` may rise after Ek+1.
- Minimum turnaround, write to next possible LOAD of the same buffer: 4 cycles.
- No-ack attempt: WAIT_ACK lasts ACK_TIMEOUT cycles, then 1 LOAD cycle per retry.
- Worst-case word occupancy: (MAX_RETRY+1)·(ACK_TIMEOUT+1)+1 cycles.
- Reset asserted mid-operation: outputs go to reset values immediately (asynchronous); buffered words are lost; `ser_load` is never left high.

## Test plan
- **Single write then start:** write addr=0, data=2; `start_tx`=1; ack 3 cycles after `ser_load` → one `ser_load` with 0/2, one `tx_done`, `buf_valid`=00, `tx_sel`=1.
- **Fill both buffers:** write (0,2), (1,8) with `start_tx`=0, then a third write (2,67) → `wr_ready`=0 and the third write is dropped. Raise `start_tx`, ack each → loads in order (0,2), (1,8).
- **No ack, defaults:** ACK_TIMEOUT=64, MAX_RETRY=2 → 3 `ser_load` pulses 65 cycles apart, then `tx_drop`, buffer freed, `tx_done` never pulses.
- **Ack on the final timeout cycle of the last attempt** → `tx_done`, no `tx_drop`.
- **`ser_busy` high** with a valid buffer and `start_tx`=1 → FSM stays IDLE; LOAD occurs the cycle after `ser_busy` falls.
- **Reset mid-WAIT_ACK** with both buffers full → all outputs at reset values. After release: `wr_ready`=1, `fill_sel`=0, and no stale `ser_load`.
